// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the default data-memory size.
package lsu_defs;

   localparam int unsigned MEM_BYTES_DEFAULT = 1024;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational little-endian lane steering: load extract/extend and
// sub-word store merge into a 32-bit memory word.
module lsu_lane_align
   import lsu_defs::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] rdata_o,
   output logic [31:0] merged_o
);

   logic [4:0]  byte_sh_s;
   logic [4:0]  half_sh_s;
   logic [31:0] shifted_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic [31:0] byte_mask_s;
   logic [31:0] half_mask_s;

   assign byte_sh_s   = {addr_i, 3'b000};
   assign half_sh_s   = {addr_i[1], 4'b0000};
   assign shifted_s   = word_i >> byte_sh_s;
   assign byte_s      = shifted_s[7:0];
   assign half_s      = addr_i[1] ? word_i[31:16] : word_i[15:0];
   assign byte_mask_s = 32'h0000_00FF << byte_sh_s;
   assign half_mask_s = 32'h0000_FFFF << half_sh_s;

   always_comb begin
      rdata_o  = 32'h0000_0000;
      merged_o = word_i;
      case (size_i)
         SZ_BYTE: begin
            rdata_o  = {{24{~unsigned_i & byte_s[7]}}, byte_s};
            merged_o = (word_i & ~byte_mask_s) | ({24'h00_0000, wdata_i[7:0]} << byte_sh_s);
         end
         SZ_HALF: begin
            rdata_o  = {{16{~unsigned_i & half_s[15]}}, half_s};
            merged_o = (word_i & ~half_mask_s) | ({16'h0000, wdata_i[15:0]} << half_sh_s);
         end
         SZ_WORD: begin
            rdata_o  = word_i;
            merged_o = wdata_i;
         end
         default: begin
            rdata_o  = 32'h0000_0000;
            merged_o = word_i;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores as read-modify-write.
// Optional LSU_COUNT_EN adds saturating load/store/fault response counters.
module load_store_unit
   import lsu_defs::*;
#(
   parameter int unsigned MEM_BYTES  = MEM_BYTES_DEFAULT,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_fault,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   output logic                  mem_memwrite,
   output logic                  mem_memread,
   input  logic [31:0]           mem_read_data
`ifdef LSU_COUNT_EN
   ,
   output logic [15:0]           load_count,
   output logic [15:0]           store_count,
   output logic [15:0]           fault_count
`endif
);

   lsu_state_e            state_q, state_d;
   logic                  write_q, uns_q, fault_q;
   logic [1:0]            size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q, word_q;
   logic                  accept_s, fault_s;
   logic [31:0]           ld_data_s, merged_s;

   assign accept_s = req_valid && (state_q == ST_IDLE);
   assign fault_s  = (req_size == 2'b11)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || (req_addr >= ADDR_WIDTH'(MEM_BYTES));

   lsu_lane_align u_align (
      .word_i     (word_q),
      .wdata_i    (wdata_q),
      .addr_i     (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .rdata_o    (ld_data_s),
      .merged_o   (merged_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
         fault_q <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= 32'h0000_0000;
         word_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         if (accept_s) begin
            write_q <= req_write;
            uns_q   <= req_unsigned;
            fault_q <= fault_s;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state_q == ST_CAP) begin
            word_q <= mem_read_data;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      mem_memread  = 1'b0;
      mem_memwrite = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (accept_s) begin
               if (fault_s)                                  state_d = ST_RESP;
               else if (req_write && (req_size == SZ_WORD))  state_d = ST_WR;
               else                                          state_d = ST_RD;
            end
         end
         ST_RD: begin
            mem_memread = 1'b1;
            state_d     = ST_CAP;
         end
         ST_CAP: begin
            mem_memread = 1'b1;
            state_d     = write_q ? ST_WR : ST_RESP;
         end
         ST_WR: begin
            mem_memwrite = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Word stores bypass the merge so no read is needed before the write.
   assign mem_address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_write_data = (size_q == SZ_WORD) ? wdata_q : merged_s;
   assign resp_fault     = resp_valid && fault_q;
   assign resp_rdata     = (resp_valid && !write_q && !fault_q) ? ld_data_s : 32'h0000_0000;

`ifdef LSU_COUNT_EN
   logic [15:0] load_cnt_q, store_cnt_q, fault_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         load_cnt_q  <= 16'h0000;
         store_cnt_q <= 16'h0000;
         fault_cnt_q <= 16'h0000;
      end else if (state_q == ST_RESP) begin
         if (fault_q) begin
            if (fault_cnt_q != 16'hFFFF) fault_cnt_q <= fault_cnt_q + 16'h0001;
         end else if (write_q) begin
            if (store_cnt_q != 16'hFFFF) store_cnt_q <= store_cnt_q + 16'h0001;
         end else begin
            if (load_cnt_q != 16'hFFFF) load_cnt_q <= load_cnt_q + 16'h0001;
         end
      end
   end

   assign load_count  = load_cnt_q;
   assign store_count = store_cnt_q;
   assign fault_count = fault_cnt_q;
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-wide data memory (address / write_data / memwrite / memread / read_data).
- Accepts one load or store request at a time and supports byte, halfword and word sizes.
- Sub-word stores are done as read-modify-write on the 32-bit word.
- Loads return sign- or zero-extended data; misaligned or out-of-range requests are rejected without touching memory.

Parameters:
- MEM_BYTES, 1024, size of data memory in bytes; any req_addr >= MEM_BYTES faults.
- ADDR_WIDTH, 32, width of req_addr and mem_address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (faults).
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse, request complete.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid; misaligned / out of range / illegal size.
- mem_address  out  ADDR_WIDTH  word-aligned address {req_addr[hi:2],2'b00}.
- mem_write_data  out  32  merged word to write.
- mem_memwrite  out  1  write strobe.
- mem_memread  out  1  read strobe.
- mem_read_data  in  32  word returned by memory.

Behaviour:
- Request is accepted on the rising edge where req_valid && req_ready. All request fields are latched, so the upstream stage may change them afterwards.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0; half at addr[1]=0 selects bits 15:0.
- States: IDLE, RD, CAP, WR, RESP.
- Transitions from IDLE on accept:
  - Fault -> RESP.
  - Word store -> WR.
  - Any load or sub-word store -> RD.
- Remaining transitions:
  - RD -> CAP.
  - CAP -> RESP for a load; CAP -> WR for a sub-word store.
  - WR -> RESP.
  - RESP -> IDLE.
- Memory strobes:
  - mem_memread = 1 in RD and CAP; mem_read_data is sampled at the end of CAP into a word register.
  - mem_memwrite = 1 only in WR; mem_address and mem_write_data are stable throughout WR.
  - mem_memread and mem_memwrite are never both high.
- Merge rule: the captured word has only the selected lanes replaced by req_wdata[7:0] or [15:0]. Word store writes req_wdata unchanged.
- Latency from the accept edge to the first cycle resp_valid is high:
  - fault: 1 cycle;
  - word store: 2;
  - load: 3;
  - sub-word store: 4.
- resp_valid is high for exactly one cycle (in RESP). There is no backpressure.
- req_ready is 0 in every state except IDLE, so back-to-back requests are separated by at least one IDLE cycle.
- Fault conditions:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size 11;
  - addr >= MEM_BYTES.
- On fault: no memory strobe is ever raised, resp_fault = 1, resp_rdata = 0.
- Reset values: state IDLE, req_ready 1 (from the cycle after the reset edge), resp_valid 0, resp_rdata 0, resp_fault 0, mem_memwrite 0, mem_memread 0, mem_address 0, mem_write_data 0.
- Reset mid-operation: the FSM aborts to IDLE with no response. A sub-word store aborted before WR leaves memory unchanged.
- reset takes priority over req_valid in the same cycle.

Optional Feature:
- Macro: LSU_COUNT_EN.
- Defined: adds outputs load_count[15:0], store_count[15:0], fault_count[15:0].
  - Each increments on a resp_valid of its class and saturates at 16'hFFFF.
  - A faulting request counts only in fault_count.
  - All clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package lsu_defs holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - FSM state encodings;
  - the default MEM_BYTES.
- Sub-module lsu_lane_align, combinational, provides:
  - load extract/extend (word, addr[1:0], size, unsigned -> rdata);
  - store merge (old word, wdata, addr[1:0], size -> new word).
- The FSM and registers stay in load_store_unit.

Test Plan:
- Word store addr 0x10, wdata 0xDEADBEEF -> one WR cycle with mem_address 0x10; resp_valid 2 cycles after accept; memory word 0x10 = 0xDEADBEEF; resp_rdata 0; resp_fault 0.
- Signed byte load:
  - Stimulus: memory word 0x10 = 0xDEADBEEF, byte load addr 0x11, signed.
  - Response: RD and CAP strobes only; resp_rdata = 0xFFFFFFBE 3 cycles after accept.
  - Same request with req_unsigned = 1 -> resp_rdata = 0x000000BE.
- Half store addr 0x12, wdata 0x00001234 over 0xDEADBEEF -> RD, CAP, WR with mem_write_data 0x1234BEEF; resp_valid 4 cycles after accept.
- Faults:
  - Word load addr 0x13 -> resp_fault 1, resp_rdata 0, resp_valid 1 cycle after accept, no strobe ever raised.
  - Same for addr 0x400 with MEM_BYTES = 1024.
  - Same for req_size 11.
- Reset in CAP of a byte store addr 0x20 (prior word 0x11223344) -> no resp_valid; memory word stays 0x11223344; req_ready 1 the cycle after the reset edge; the next request completes normally.
- With LSU_COUNT_EN: 3 loads, 2 stores, 1 fault -> load_count 3, store_count 2, fault_count 1; after reset all 0.
